// File: rtl/uart_rx.sv
// 8N1 UART receiver. It samples each bit at mid-bit and holds the last byte with valid,
// framing-error and overrun flags, and it pulses rx_int once for every committed frame.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Rx,
  input  logic       rd_ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_int
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             rx_int_q, rx_int_d;
  logic             sync1_q, rxs_q;
  logic             rxs;

  assign rxs = rxs_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    rx_int_d    = 1'b0;

    if (rd_ack && valid_q) begin
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          shift_d   = {rxs, shift_q[7:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          // Commit overrides any same-cycle rd_ack clear above.
          data_d      = shift_q;
          valid_d     = 1'b1;
          frame_err_d = ~rxs;
          overrun_d   = overrun_q | (valid_q & ~rd_ack);
          rx_int_d    = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_int_q    <= 1'b0;
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rx_int_q    <= rx_int_d;
      sync1_q     <= Rx;
      rxs_q       <= sync1_q;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_int    = rx_int_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of single frames, plus hand-written sequences for the
// glitch, back-to-back, same-cycle ack and mid-frame reset cases.
module tb_uart_rx;

  localparam int CPB  = 50_000_000 / 115200;
  localparam int HALF = CPB / 2;
  // Two synchronizer cycles, the stop-bit sample point, and one cycle to register the result.
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rdAck = 1'b0;
  logic [7:0] data;
  logic       valid, frameErr, overrun, rxInt;

  int cyc = 0;
  int intCount = 0;
  int lastIntCycle = -1;
  int startCyc = 0;
  int frameCount = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] txByte;
    int         cpb;
    logic       stopBit;
    logic [7:0] expData;
    logic       expFerr;
  } vec_t;

  vec_t vecs[5];

  uart_rx dut (
    .CLK(clk), .RST(rst), .Rx(rx), .rd_ack(rdAck),
    .data(data), .valid(valid), .frame_err(frameErr),
    .overrun(overrun), .rx_int(rxInt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rxInt) begin
      intCount     = intCount + 1;
      lastIntCycle = cyc;
    end
  end

  initial begin
    #(900_000 * 1ns);
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual != expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int cpb, input logic stopBit);
    @(negedge clk);
    rx = 1'b0;
    startCyc = cyc;
    frameCount = frameCount + 1;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (cpb) @(negedge clk);
    end
    rx = stopBit;
    repeat (cpb) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic ackByte();
    @(negedge clk);
    rdAck = 1'b1;
    @(negedge clk);
    rdAck = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int prevInts;
    prevInts = intCount;
    sendByte(v.txByte, v.cpb, v.stopBit);
    repeat (20) @(negedge clk);
    checkOutput($sformatf("vec%0d data", idx), int'(data), int'(v.expData));
    checkOutput($sformatf("vec%0d valid", idx), int'(valid), 1);
    checkOutput($sformatf("vec%0d frame_err", idx), int'(frameErr), int'(v.expFerr));
    checkOutput($sformatf("vec%0d overrun", idx), int'(overrun), 0);
    checkOutput($sformatf("vec%0d rx_int count", idx), intCount - prevInts, 1);
    checkOutput($sformatf("vec%0d rx_int latency", idx), lastIntCycle - startCyc, LAT);
    ackByte();
    checkOutput($sformatf("vec%0d valid after ack", idx), int'(valid), 0);
    checkOutput($sformatf("vec%0d frame_err after ack", idx), int'(frameErr), 0);
  endtask

  initial begin
    int prevInts;

    vecs[0] = '{txByte: 8'hA5, cpb: CPB,     stopBit: 1'b1, expData: 8'hA5, expFerr: 1'b0};
    vecs[1] = '{txByte: 8'h3C, cpb: CPB,     stopBit: 1'b1, expData: 8'h3C, expFerr: 1'b0};
    vecs[2] = '{txByte: 8'h81, cpb: CPB,     stopBit: 1'b0, expData: 8'h81, expFerr: 1'b1};
    vecs[3] = '{txByte: 8'h96, cpb: 443,     stopBit: 1'b1, expData: 8'h96, expFerr: 1'b0};
    vecs[4] = '{txByte: 8'h96, cpb: 425,     stopBit: 1'b1, expData: 8'h96, expFerr: 1'b0};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset data", int'(data), 0);
    checkOutput("reset valid", int'(valid), 0);
    checkOutput("reset frame_err", int'(frameErr), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    checkOutput("reset rx_int", int'(rxInt), 0);

    // A 100-cycle low pulse is shorter than half a bit and must be rejected.
    prevInts = intCount;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    checkOutput("glitch rx_int count", intCount - prevInts, 0);
    checkOutput("glitch valid", int'(valid), 0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Back-to-back without acknowledge: the second byte overwrites and flags overrun.
    prevInts = intCount;
    sendByte(8'h11, CPB, 1'b1);
    sendByte(8'h22, CPB, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("b2b data", int'(data), 8'h22);
    checkOutput("b2b valid", int'(valid), 1);
    checkOutput("b2b overrun", int'(overrun), 1);
    checkOutput("b2b rx_int count", intCount - prevInts, 2);
    ackByte();
    checkOutput("b2b overrun after ack", int'(overrun), 0);
    checkOutput("b2b valid after ack", int'(valid), 0);

    // Same frames again with rd_ack landing exactly on the second commit edge.
    prevInts = intCount;
    frameCount = 0;
    fork
      begin
        sendByte(8'h11, CPB, 1'b1);
        sendByte(8'h22, CPB, 1'b1);
      end
      begin
        wait (frameCount == 2);
        repeat (LAT - 1) @(negedge clk);
        rdAck = 1'b1;
        @(negedge clk);
        rdAck = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    checkOutput("b2b-ack data", int'(data), 8'h22);
    checkOutput("b2b-ack valid", int'(valid), 1);
    checkOutput("b2b-ack overrun", int'(overrun), 0);
    checkOutput("b2b-ack rx_int count", intCount - prevInts, 2);
    ackByte();

    // Reset during data bit 4 of 0xFF abandons the frame.
    prevInts = intCount;
    frameCount = 0;
    fork
      sendByte(8'hFF, CPB, 1'b1);
      begin
        wait (frameCount == 1);
        repeat (5 * CPB + 200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    checkOutput("abort rx_int count", intCount - prevInts, 0);
    checkOutput("abort valid", int'(valid), 0);
    checkOutput("abort data", int'(data), 0);
    sendByte(8'h5A, CPB, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("after abort data", int'(data), 8'h5A);
    checkOutput("after abort valid", int'(valid), 1);
    checkOutput("after abort rx_int count", intCount - prevInts, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
